// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache in front of the fetch stage.
//
// One word-aligned fetch is handled at a time. On a hit the word comes straight
// from the flop-based line storage. On a miss the whole line is refilled from
// the memory port as a burst of single-word beats, in ascending word order.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   req_valid/req_ready  fetch request handshake; req_address is a byte address
//                        whose bits [1:0] are ignored
//   resp_valid/ready     response handshake; resp_data is the instruction word
//                        and resp_address echoes the request (bits [1:0] = 0)
//   invalidate           clears every line valid bit (fence.i / trap flush)
//   mem_req_*            line refill request; mem_req_address is the line base
//   mem_resp_valid/data  refill beats, accepted only while a refill is pending
module icache #(
    parameter int NUM_LINES    = 16,
    parameter int INDEX_WIDTH  = 4,
    parameter int LINE_WORDS   = 4,
    parameter int OFFSET_WIDTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_address,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_address,
    output logic [31:0] resp_data,
    input  logic        invalidate,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_address,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    localparam int IDX_LSB   = 2 + OFFSET_WIDTH;
    localparam int TAG_LSB   = IDX_LSB + INDEX_WIDTH;
    localparam int TAG_WIDTH = 32 - TAG_LSB;
    localparam logic [OFFSET_WIDTH-1:0] LAST_BEAT = OFFSET_WIDTH'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL_REQ,
        REFILL_WAIT,
        RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [31:0]             addr_q, addr_d;
    logic [NUM_LINES-1:0]    valid_q, valid_d;
    logic [TAG_WIDTH-1:0]    tag_q  [NUM_LINES];
    logic [TAG_WIDTH-1:0]    tag_d  [NUM_LINES];
    logic [31:0]             data_q [NUM_LINES][LINE_WORDS];
    logic [31:0]             data_d [NUM_LINES][LINE_WORDS];
    logic [OFFSET_WIDTH-1:0] beat_q, beat_d;
    logic                    poison_q, poison_d;
    logic [31:0]             resp_data_q, resp_data_d;
    logic [31:0]             resp_address_q, resp_address_d;

    logic [INDEX_WIDTH-1:0]  index;
    logic [OFFSET_WIDTH-1:0] offset;
    logic [TAG_WIDTH-1:0]    req_tag;
    logic                    hit;

    // The byte-offset bits of the fetch address carry no information.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_address[1:0];

    // All lookups use the latched request address, never the live input.
    assign index   = addr_q[TAG_LSB-1:IDX_LSB];
    assign offset  = addr_q[IDX_LSB-1:2];
    assign req_tag = addr_q[31:TAG_LSB];
    assign hit     = valid_q[index] && (tag_q[index] == req_tag);

    assign resp_data       = resp_data_q;
    assign resp_address    = resp_address_q;
    assign mem_req_address = {addr_q[31:IDX_LSB], {IDX_LSB{1'b0}}};

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        valid_d        = valid_q;
        tag_d          = tag_q;
        data_d         = data_q;
        beat_d         = beat_q;
        poison_d       = poison_q;
        resp_data_d    = resp_data_q;
        resp_address_d = resp_address_q;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        mem_req_valid  = 1'b0;

        // Invalidate wins in every state; an accepted request in the same
        // cycle therefore looks up an already-empty cache.
        if (invalidate) begin
            valid_d = '0;
        end

        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d   = {req_address[31:2], 2'b00};
                    poison_d = 1'b0;
                    state_d  = LOOKUP;
                end
            end
            LOOKUP: begin
                resp_address_d = addr_q;
                if (hit) begin
                    resp_data_d = data_q[index][offset];
                    state_d     = RESP;
                end else begin
                    state_d = REFILL_REQ;
                end
            end
            REFILL_REQ: begin
                mem_req_valid = 1'b1;
                if (invalidate) begin
                    poison_d = 1'b1;
                end
                if (mem_req_ready) begin
                    beat_d  = '0;
                    state_d = REFILL_WAIT;
                end
            end
            REFILL_WAIT: begin
                if (invalidate) begin
                    poison_d = 1'b1;
                end
                if (mem_resp_valid) begin
                    data_d[index][beat_q] = mem_resp_data;
                    beat_d                = beat_q + 1'b1;
                    if (beat_q == offset) begin
                        resp_data_d = mem_resp_data;
                    end
                    // A poisoned line is still written and answered from, but
                    // must not be trusted by any later lookup.
                    if (beat_q == LAST_BEAT) begin
                        tag_d[index]   = req_tag;
                        valid_d[index] = !(poison_q || invalidate);
                        state_d        = RESP;
                    end
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and response registers; reset abandons any refill in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            valid_q        <= '0;
            beat_q         <= '0;
            poison_q       <= 1'b0;
            resp_data_q    <= '0;
            resp_address_q <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            valid_q        <= valid_d;
            beat_q         <= beat_d;
            poison_q       <= poison_d;
            resp_data_q    <= resp_data_d;
            resp_address_q <= resp_address_d;
        end
    end

    // Tag and data storage is left unreset; the valid bits alone gate hits.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed, self-checking bench for icache.
//
// Each fetch pushes its expected {address, word} onto a scoreboard queue when
// the request is driven; the entry is popped and compared when the cache
// completes the response handshake. A small memory responder inside the bench
// serves refills with the beat values chosen by each directed step.
module tb_icache;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_address = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_address;
    logic [31:0] resp_data;
    logic        invalidate = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_address;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    icache dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_address     (req_address),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_address    (resp_address),
        .resp_data       (resp_data),
        .invalidate      (invalidate),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_address (mem_req_address),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data)
    );

    // Single comparison point: every check in the bench goes through here.
    task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issue one fetch (optionally with invalidate in the same cycle) and queue
    // the response the fetch stage should eventually see.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] exp_data, input logic inval);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        compare("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid   = 1'b1;
        req_address = addr;
        invalidate  = inval;
        e.addr      = {addr[31:2], 2'b00};
        e.data      = exp_data;
        sb.push_back(e);
        @(negedge clk);
        req_valid  = 1'b0;
        invalidate = 1'b0;
        compare("req_ready_busy", 32'(req_ready), 32'd0);
    endtask

    // Hit path: still in lookup one cycle after accept, response the next.
    task automatic checkHit();
        compare("hit_lookup_resp_valid", 32'(resp_valid), 32'd0);
        compare("hit_lookup_mem_req", 32'(mem_req_valid), 32'd0);
        @(negedge clk);
        compare("hit_resp_valid", 32'(resp_valid), 32'd1);
        compare("hit_mem_req", 32'(mem_req_valid), 32'd0);
    endtask

    // Miss path: expect a line request, then stream four beats. inval_beat
    // selects a beat during which invalidate is held (-1 for none).
    task automatic serveRefill(input logic [31:0] line_addr, input logic [3:0][31:0] beats,
                               input int inval_beat);
        int n = 0;
        while (!mem_req_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        compare("mem_req_valid", 32'(mem_req_valid), 32'd1);
        if (!mem_req_valid) return;
        compare("mem_req_address", mem_req_address, line_addr);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        compare("mem_req_dropped", 32'(mem_req_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = beats[i];
            invalidate     = (i == inval_beat);
            @(negedge clk);
            compare((i < 3) ? "refill_resp_low" : "refill_resp_high",
                    32'(resp_valid), (i < 3) ? 32'd0 : 32'd1);
        end
        mem_resp_valid = 1'b0;
        invalidate     = 1'b0;
    endtask

    // Hold off the response for 'stall' cycles, then take it and score it.
    task automatic checkOutput(input int stall);
        int   n = 0;
        exp_t e;
        while (!resp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        compare("sb_not_empty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb[0];
        for (int s = 0; s < stall; s++) begin
            resp_ready = 1'b0;
            @(negedge clk);
            compare("stall_resp_valid", 32'(resp_valid), 32'd1);
            compare("stall_resp_data", resp_data, e.data);
            compare("stall_resp_address", resp_address, e.addr);
            compare("stall_req_ready", 32'(req_ready), 32'd0);
        end
        e = sb.pop_front();
        resp_ready = 1'b1;
        compare("resp_valid", 32'(resp_valid), 32'd1);
        compare("resp_data", resp_data, e.data);
        compare("resp_address", resp_address, e.addr);
        @(negedge clk);
        resp_ready = 1'b0;
        compare("resp_done_valid", 32'(resp_valid), 32'd0);
        compare("resp_done_req_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic checkResetOutputs();
        compare("rst_req_ready", 32'(req_ready), 32'd1);
        compare("rst_resp_valid", 32'(resp_valid), 32'd0);
        compare("rst_resp_data", resp_data, 32'd0);
        compare("rst_resp_address", resp_address, 32'd0);
        compare("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        compare("rst_mem_req_address", mem_req_address, 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkResetOutputs();

        // Cold miss, word 1 of line 0x8000_0000.
        applyStimulus(32'h8000_0004, 32'h22, 1'b0);
        serveRefill(32'h8000_0000, {32'h44, 32'h33, 32'h22, 32'h11}, -1);
        checkOutput(0);

        // Hit on the freshly filled line.
        applyStimulus(32'h8000_000C, 32'h44, 1'b0);
        checkHit();
        checkOutput(0);

        // Same index, different tag: evicts, then the old line misses again.
        applyStimulus(32'h8000_0100, 32'hA0, 1'b0);
        serveRefill(32'h8000_0100, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, -1);
        checkOutput(0);
        applyStimulus(32'h8000_0004, 32'h22, 1'b0);
        serveRefill(32'h8000_0000, {32'h44, 32'h33, 32'h22, 32'h11}, -1);
        checkOutput(0);

        // Backpressure on a hit, with ignored low address bits.
        applyStimulus(32'h8000_000B, 32'h33, 1'b0);
        checkHit();
        checkOutput(3);

        // Invalidate during a refill: word delivered, line left invalid.
        applyStimulus(32'h8000_0010, 32'h51, 1'b0);
        serveRefill(32'h8000_0010, {32'h54, 32'h53, 32'h52, 32'h51}, 1);
        checkOutput(0);
        applyStimulus(32'h8000_0010, 32'h51, 1'b0);
        serveRefill(32'h8000_0010, {32'h54, 32'h53, 32'h52, 32'h51}, -1);
        checkOutput(0);

        // Line 0 was flushed too; refill it, confirm a hit, then invalidate
        // together with the request so it misses.
        applyStimulus(32'h8000_0000, 32'h11, 1'b0);
        serveRefill(32'h8000_0000, {32'h44, 32'h33, 32'h22, 32'h11}, -1);
        checkOutput(0);
        applyStimulus(32'h8000_0004, 32'h22, 1'b0);
        checkHit();
        checkOutput(0);
        applyStimulus(32'h8000_000C, 32'h44, 1'b1);
        serveRefill(32'h8000_0000, {32'h44, 32'h33, 32'h22, 32'h11}, -1);
        checkOutput(0);

        // Reset after two beats of a refill, then stray beats.
        applyStimulus(32'h8000_0040, 32'h0, 1'b0);
        n = 0;
        while (!mem_req_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        compare("mid_mem_req_address", mem_req_address, 32'h8000_0040);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'h61 + i;
            @(negedge clk);
        end
        mem_resp_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        checkResetOutputs();
        for (int i = 0; i < 2; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hDEAD_0000 + i;
            @(negedge clk);
            compare("stray_resp_valid", 32'(resp_valid), 32'd0);
            compare("stray_mem_req_valid", 32'(mem_req_valid), 32'd0);
            compare("stray_req_ready", 32'(req_ready), 32'd1);
        end
        mem_resp_valid = 1'b0;
        applyStimulus(32'h8000_0044, 32'h72, 1'b0);
        serveRefill(32'h8000_0040, {32'h74, 32'h73, 32'h72, 32'h71}, -1);
        checkOutput(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache sitting directly upstream of the fetch stage.
- Serves one word-aligned fetch request at a time over a valid/ready request/response pair: fetch address in; instruction word plus its echoed address out.
- On a miss, refills one full line from the memory-side port as a burst of single-word beats.
- Supports whole-cache invalidation (fence.i / trap flush).

Parameters:
- NUM_LINES, 16, number of cache lines; power of two.
- INDEX_WIDTH, 4, log2(NUM_LINES).
- LINE_WORDS, 4, 32-bit words per line; power of two, at least 2.
- OFFSET_WIDTH, 2, log2(LINE_WORDS).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  cache can accept a request.
- req_address  in  32  fetch byte address; bits [1:0] ignored.
- resp_valid  out  1  response word valid.
- resp_ready  in  1  fetch can take the response.
- resp_address  out  32  address of the request being answered, bits [1:0] forced to 0.
- resp_data  out  32  instruction word.
- invalidate  in  1  clear all line valid bits.
- mem_req_valid  out  1  line refill request valid.
- mem_req_ready  in  1  memory accepts the refill request.
- mem_req_address  out  32  line base address (low 2+OFFSET_WIDTH bits zero).
- mem_resp_valid  in  1  refill beat valid; beats arrive in ascending word order.
- mem_resp_data  in  32  refill beat data.

Behaviour:
- Address split:
  - tag = addr[31 : 2+OFFSET_WIDTH+INDEX_WIDTH]; 24 bits at defaults.
  - index = addr[2+OFFSET_WIDTH+INDEX_WIDTH-1 : 2+OFFSET_WIDTH].
  - offset = addr[2+OFFSET_WIDTH-1 : 2].
- Storage: tag, valid and data arrays held in flops; read combinationally from the latched request address.
- FSM states: IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready: latch the address; go to LOOKUP.
- LOOKUP:
  - Hit = valid[index] && tag match.
  - Hit: load resp_data/resp_address registers; go to RESP.
  - Miss: go to REFILL_REQ.
- REFILL_REQ:
  - mem_req_valid = 1; mem_req_address = latched address with the low 2+OFFSET_WIDTH bits cleared.
  - On mem_req_ready: clear the beat counter; go to REFILL_WAIT.
- REFILL_WAIT:
  - Each mem_resp_valid writes data[index][beat] and increments the beat counter (wraps at LINE_WORDS).
  - When beat == offset, capture the word into resp_data.
  - On the last beat: write tag; set valid unless the refill is poisoned; go to RESP.
- RESP:
  - resp_valid = 1; resp_data and resp_address stay stable while resp_ready = 0.
  - On resp_ready: go to IDLE.
- req_ready is 0 in every state except IDLE; a single request is outstanding at a time.
- Latency:
  - Hit: resp_valid rises 2 cycles after the accepting edge.
  - Miss: resp_valid rises 1 cycle after the last refill beat.
  - No speculative prefetch.
- The response is always returned, even if fetch has since redirected; fetch filters it by address.
- invalidate:
  - Clears all valid bits at the next edge, in any state.
  - Asserted during REFILL_REQ/REFILL_WAIT, it poisons that refill: the line is written and the response delivered, but valid stays 0.
  - Asserted in IDLE together with an accepted request: the invalidate takes effect first, so the request misses.
- mem_resp_valid outside REFILL_WAIT is ignored (stray beats after a reset are dropped).
- Reset values:
  - State IDLE; all valid bits 0; beat counter 0; poison flag 0.
  - resp_valid 0, resp_data 0, resp_address 0, mem_req_valid 0, mem_req_address 0.
  - req_ready is 1 from the first cycle after reset.
  - Reset mid-refill abandons the refill; the line stays invalid.
- Data and tag arrays are not reset; valid bits alone gate hits.

Test Plan:
- Cold miss:
  - Stimulus: request 0x8000_0004; memory returns beats 0x11, 0x22, 0x33, 0x44.
  - Response: mem_req_address = 0x8000_0000; resp_data = 0x22; resp_address = 0x8000_0004; resp_valid 1 cycle after beat 4.
- Hit after fill:
  - Stimulus: request 0x8000_000C.
  - Response: resp_data = 0x44 two cycles after accept; mem_req_valid stays 0.
- Conflict eviction:
  - Stimulus: request 0x8000_0100 (index 0, new tag); beats 0xA0–0xA3.
  - Response: resp_data = 0xA0; a following request to 0x8000_0004 misses again.
- Backpressure:
  - Stimulus: hold resp_ready = 0 for 3 cycles during a hit.
  - Response: resp_valid, resp_data and resp_address stable; req_ready = 0; the response completes on the cycle resp_ready = 1.
- Invalidate:
  - Stimulus: invalidate during REFILL_WAIT of 0x8000_0010.
  - Response: the word is still delivered; the next request to 0x8000_0010 issues a new mem_req. Invalidate in IDLE makes 0x8000_000C miss.
- Reset mid-refill:
  - Stimulus: reset after beat 2; 2 stray beats follow.
  - Response: all outputs at reset values; stray beats ignored; the next request to the same line misses.
